// File: rtl/accel_flow_pkg.sv
// -----------------------------------------------------------------------------
// accel_flow_pkg
// Shared types and defaults for the accel_flow_seq token pipeline sequencer.
//   slot_state_e : per-stage slot state (IDLE/RUN/HOLD/PASS)
//   top_state_e  : layer-level sequencer state (IDLE/ACTIVE/DONE)
//   DEF_*        : default parameter values
// -----------------------------------------------------------------------------
package accel_flow_pkg;

  typedef enum logic [1:0] {
    SLOT_IDLE = 2'd0,
    SLOT_RUN  = 2'd1,
    SLOT_HOLD = 2'd2,
    SLOT_PASS = 2'd3
  } slot_state_e;

  typedef enum logic [1:0] {
    TOP_IDLE   = 2'd0,
    TOP_ACTIVE = 2'd1,
    TOP_DONE   = 2'd2
  } top_state_e;

  localparam int DEF_N_STAGE = 4;
  localparam int DEF_META_W  = 72;
  localparam int DEF_CNT_W   = 16;

endpackage

// File: rtl/accel_flow_slot.sv
// -----------------------------------------------------------------------------
// accel_flow_slot
// One pipeline slot: holds a token (metadata, last flag, per-token skip
// vector), issues the one-cycle stage start pulse and reports done / bad fin.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   enb, clear        : global enable (freeze), synchronous flush
//   load_i            : a token enters this slot at the next edge
//   load_skip_i       : effective skip bit for the entering token
//   load_meta_i/last_i/skipv_i : entering token payload
//   vac_i             : token leaves this slot at the next edge
//   fin_i             : stage finished current token
//   state_o           : current slot state
//   start_o           : stage start pulse (first RUN cycle)
//   meta_o/last_o/skipv_o : held token payload
//   done_o            : token ready to move on
//   fin_err_o         : fin seen while not in RUN
// -----------------------------------------------------------------------------
module accel_flow_slot
  import accel_flow_pkg::*;
#(
  parameter int N_STAGE = DEF_N_STAGE,
  parameter int META_W  = DEF_META_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enb,
  input  logic               clear,
  input  logic               load_i,
  input  logic               load_skip_i,
  input  logic [META_W-1:0]  load_meta_i,
  input  logic               load_last_i,
  input  logic [N_STAGE-1:0] load_skipv_i,
  input  logic               vac_i,
  input  logic               fin_i,
  output slot_state_e        state_o,
  output logic               start_o,
  output logic [META_W-1:0]  meta_o,
  output logic               last_o,
  output logic [N_STAGE-1:0] skipv_o,
  output logic               done_o,
  output logic               fin_err_o
);

  slot_state_e        state_q, state_d;
  logic               first_q, first_d;
  logic [META_W-1:0]  meta_q, meta_d;
  logic               last_q, last_d;
  logic [N_STAGE-1:0] skipv_q, skipv_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SLOT_IDLE;
      first_q <= 1'b0;
      meta_q  <= '0;
      last_q  <= 1'b0;
      skipv_q <= '0;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
      meta_q  <= meta_d;
      last_q  <= last_d;
      skipv_q <= skipv_d;
    end
  end

  // A load can coincide with the current token leaving (back-to-back
  // transfer), so load takes priority over vacate.
  always_comb begin
    state_d = state_q;
    first_d = first_q;
    meta_d  = meta_q;
    last_d  = last_q;
    skipv_d = skipv_q;
    if (clear) begin
      state_d = SLOT_IDLE;
      first_d = 1'b0;
    end else if (enb) begin
      if (load_i) begin
        state_d = load_skip_i ? SLOT_PASS : SLOT_RUN;
        first_d = ~load_skip_i;
        meta_d  = load_meta_i;
        last_d  = load_last_i;
        skipv_d = load_skipv_i;
      end else if (vac_i) begin
        state_d = SLOT_IDLE;
        first_d = 1'b0;
      end else if (state_q == SLOT_RUN) begin
        first_d = 1'b0;
        if (fin_i) begin
          state_d = SLOT_HOLD;
        end
      end
    end
  end

  assign state_o   = state_q;
  assign start_o   = enb & first_q & (state_q == SLOT_RUN);
  assign meta_o    = meta_q;
  assign last_o    = last_q & (state_q != SLOT_IDLE);
  assign skipv_o   = skipv_q;
  // fin is honoured in the start cycle itself, allowing zero-latency stages.
  assign done_o    = enb & ((state_q == SLOT_PASS) | (state_q == SLOT_HOLD) |
                            ((state_q == SLOT_RUN) & fin_i));
  assign fin_err_o = enb & fin_i & (state_q != SLOT_RUN);

endmodule

// File: rtl/accel_flow_seq.sv
// -----------------------------------------------------------------------------
// accel_flow_seq
// In-order N_STAGE token pipeline sequencer. Tokens from an upstream address
// generator walk through N_STAGE stage controllers using start/fin handshakes,
// with per-layer and per-token stage skipping.
// Ports:
//   clk, reset     : clock, asynchronous active-high reset
//   enb            : global enable, low freezes everything
//   clear          : synchronous flush (overrides enb/start)
//   start          : layer launch pulse
//   cfg_num_tiles  : tiles in the layer
//   cfg_skip_mask  : layer-static stage skip (bit0 ignored)
//   tok_valid/tok_ready/tok_meta/tok_skip : upstream token handshake
//   stg_start      : per-stage start pulse
//   stg_meta       : per-slot token metadata (slot i at [i*META_W +: META_W])
//   stg_last       : slot holds final tile of the layer
//   stg_fin        : per-stage finish
//   tiles_retired  : tokens vacated from the last slot
//   busy, cal_fin  : layer active, one-cycle layer-complete pulse
//   err_fin_unexp  : sticky, fin seen while slot not RUN
// -----------------------------------------------------------------------------
module accel_flow_seq
  import accel_flow_pkg::*;
#(
  parameter int N_STAGE = DEF_N_STAGE,
  parameter int META_W  = DEF_META_W,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enb,
  input  logic                      clear,
  input  logic                      start,
  input  logic [CNT_W-1:0]          cfg_num_tiles,
  input  logic [N_STAGE-1:0]        cfg_skip_mask,
  input  logic                      tok_valid,
  output logic                      tok_ready,
  input  logic [META_W-1:0]         tok_meta,
  input  logic [N_STAGE-1:0]        tok_skip,
  output logic [N_STAGE-1:0]        stg_start,
  output logic [N_STAGE*META_W-1:0] stg_meta,
  output logic [N_STAGE-1:0]        stg_last,
  input  logic [N_STAGE-1:0]        stg_fin,
  output logic [CNT_W-1:0]          tiles_retired,
  output logic                      busy,
  output logic                      cal_fin,
  output logic                      err_fin_unexp
);

  top_state_e         top_q, top_d;
  logic [CNT_W-1:0]   issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic               err_q, err_d;

  slot_state_e        state_s [N_STAGE];
  logic [META_W-1:0]  meta_s  [N_STAGE];
  logic [N_STAGE-1:0] skipv_s [N_STAGE];
  logic [N_STAGE-1:0] done_s;
  logic [N_STAGE-1:0] fin_err_s;
  logic [N_STAGE-1:0] slot_idle;
  logic [N_STAGE-1:0] idle_sh;
  logic [N_STAGE-1:0] vac;
  logic               accept;
  logic               issue_last;

  // ---------------------------------------------------------------------------
  // Vacate ripple from the tail: a slot may hand over when the next slot is
  // empty or is itself handing over this cycle. The tail always has room.
  // ---------------------------------------------------------------------------
  assign idle_sh = {1'b1, slot_idle[N_STAGE-1:1]};

  always_comb begin
    logic carry;
    vac   = '0;
    carry = 1'b0;
    for (int i = N_STAGE - 1; i >= 0; i--) begin
      carry  = done_s[i] & (idle_sh[i] | carry);
      vac[i] = carry;
    end
  end

  assign tok_ready  = (top_q == TOP_ACTIVE) & enb & ~clear &
                      (issue_cnt_q < cfg_num_tiles) & (slot_idle[0] | vac[0]);
  assign accept     = tok_valid & tok_ready;
  assign issue_last = (issue_cnt_q == (cfg_num_tiles - CNT_W'(1)));

  // ---------------------------------------------------------------------------
  // Slots
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < N_STAGE; gi++) begin : g_slot
      logic               load;
      logic               load_skip;
      logic [META_W-1:0]  load_meta;
      logic               load_last;
      logic [N_STAGE-1:0] load_skipv;

      if (gi == 0) begin : g_head
        // Stage 0 is never skippable.
        assign load       = accept;
        assign load_skip  = 1'b0;
        assign load_meta  = tok_meta;
        assign load_last  = issue_last;
        assign load_skipv = tok_skip;
      end else begin : g_body
        assign load       = vac[gi-1];
        assign load_skip  = cfg_skip_mask[gi] | skipv_s[gi-1][gi];
        assign load_meta  = meta_s[gi-1];
        assign load_last  = stg_last[gi-1];
        assign load_skipv = skipv_s[gi-1];
      end

      accel_flow_slot #(
        .N_STAGE (N_STAGE),
        .META_W  (META_W)
      ) u_slot (
        .clk          (clk),
        .reset        (reset),
        .enb          (enb),
        .clear        (clear),
        .load_i       (load),
        .load_skip_i  (load_skip),
        .load_meta_i  (load_meta),
        .load_last_i  (load_last),
        .load_skipv_i (load_skipv),
        .vac_i        (vac[gi]),
        .fin_i        (stg_fin[gi]),
        .state_o      (state_s[gi]),
        .start_o      (stg_start[gi]),
        .meta_o       (meta_s[gi]),
        .last_o       (stg_last[gi]),
        .skipv_o      (skipv_s[gi]),
        .done_o       (done_s[gi]),
        .fin_err_o    (fin_err_s[gi])
      );

      assign slot_idle[gi]                   = (state_s[gi] == SLOT_IDLE);
      assign stg_meta[gi*META_W +: META_W]   = meta_s[gi];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Top FSM and counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      top_q       <= TOP_IDLE;
      issue_cnt_q <= '0;
      retired_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      top_q       <= top_d;
      issue_cnt_q <= issue_cnt_d;
      retired_q   <= retired_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    top_d       = top_q;
    issue_cnt_d = issue_cnt_q;
    retired_d   = retired_q;
    err_d       = err_q;
    if (clear) begin
      top_d       = TOP_IDLE;
      issue_cnt_d = '0;
      retired_d   = '0;
      err_d       = 1'b0;
    end else if (enb) begin
      case (top_q)
        TOP_IDLE: begin
          if (start) begin
            top_d       = TOP_ACTIVE;
            issue_cnt_d = '0;
            retired_d   = '0;
          end
        end
        TOP_ACTIVE: begin
          if (retired_q == cfg_num_tiles) begin
            top_d = TOP_DONE;
          end
          if (accept) begin
            issue_cnt_d = issue_cnt_q + CNT_W'(1);
          end
          if (vac[N_STAGE-1] && (retired_q != cfg_num_tiles)) begin
            retired_d = retired_q + CNT_W'(1);
          end
        end
        TOP_DONE: begin
          top_d = TOP_IDLE;
        end
        default: begin
          top_d = TOP_IDLE;
        end
      endcase
      if (|fin_err_s) begin
        err_d = 1'b1;
      end
    end
  end

  assign tiles_retired = retired_q;
  assign busy          = (top_q == TOP_ACTIVE) | (top_q == TOP_DONE);
  // Held in DONE while enb is low so the pulse is not lost.
  assign cal_fin       = (top_q == TOP_DONE) & enb;
  assign err_fin_unexp = err_q;

  // Skip bit 0 is architecturally ignored and the tail's skip vector has no
  // downstream consumer.
  logic unused_bits;
  assign unused_bits = ^{cfg_skip_mask[0], skipv_s[N_STAGE-1]};

endmodule

// File: tb/tb_accel_flow_seq.sv
module tb_accel_flow_seq;
  import accel_flow_pkg::*;

  localparam int N  = 4;
  localparam int MW = 72;
  localparam int CW = 16;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            enb = 1'b0;
  logic            clear = 1'b0;
  logic            start = 1'b0;
  logic [CW-1:0]   cfg_num_tiles = '0;
  logic [N-1:0]    cfg_skip_mask = '0;
  logic            tok_valid = 1'b0;
  logic            tok_ready;
  logic [MW-1:0]   tok_meta = '0;
  logic [N-1:0]    tok_skip = '0;
  logic [N-1:0]    stg_start;
  logic [N*MW-1:0] stg_meta;
  logic [N-1:0]    stg_last;
  logic [N-1:0]    stg_fin;
  logic [CW-1:0]   tiles_retired;
  logic            busy;
  logic            cal_fin;
  logic            err_fin_unexp;

  logic [N-1:0]    fin_model = '0;
  logic [N-1:0]    fin_inj = '0;
  logic [N-1:0]    zl_mask = '0;

  always #5 clk = ~clk;

  assign stg_fin = fin_model | fin_inj | (zl_mask & stg_start);

  accel_flow_seq #(.N_STAGE(N), .META_W(MW), .CNT_W(CW)) dut (
    .clk           (clk),
    .reset         (reset),
    .enb           (enb),
    .clear         (clear),
    .start         (start),
    .cfg_num_tiles (cfg_num_tiles),
    .cfg_skip_mask (cfg_skip_mask),
    .tok_valid     (tok_valid),
    .tok_ready     (tok_ready),
    .tok_meta      (tok_meta),
    .tok_skip      (tok_skip),
    .stg_start     (stg_start),
    .stg_meta      (stg_meta),
    .stg_last      (stg_last),
    .stg_fin       (stg_fin),
    .tiles_retired (tiles_retired),
    .busy          (busy),
    .cal_fin       (cal_fin),
    .err_fin_unexp (err_fin_unexp)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard of tokens in issue order, checked when stage N-1 starts.
  typedef struct packed {
    logic [MW-1:0] meta;
    logic          last;
  } exp_t;
  exp_t sb[$];

  function automatic logic [MW-1:0] mk_meta(input int k);
    return {8'h5A, 32'(k * 7 + 3), 32'hC0DE_0000 + 32'(k)};
  endfunction

  // Stage models: fin lat[i] cycles after start (lat 0 uses zl_mask instead).
  int lat[N] = '{default: 2};
  int cnt[N] = '{default: 0};
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (cnt[i] != 0) begin
        cnt[i]--;
        fin_model[i] = (cnt[i] == 0);
      end else begin
        fin_model[i] = 1'b0;
      end
      if (stg_start[i] && lat[i] > 0) cnt[i] = lat[i];
    end
  end

  // Upstream feeder: sample acceptance just before the active edge.
  bit           feed_en = 1'b0;
  int           feed_num = 0;
  int           feed_idx = 0;
  int           layer_base = 0;
  logic [N-1:0] feed_skip = '0;
  int           stall_cyc = 0;
  int           ready_gaps = 0;
  bit           accepted_any = 1'b0;
  always @(negedge clk) begin
    if (feed_en && feed_idx < feed_num) begin
      tok_valid = 1'b1;
      tok_meta  = mk_meta(layer_base + feed_idx);
      tok_skip  = feed_skip;
    end else begin
      tok_valid = 1'b0;
    end
    #4;
    if (tok_valid && !reset) begin
      if (tok_ready) begin
        sb.push_back('{meta: tok_meta, last: (feed_idx == feed_num - 1)});
        $display("accept token %0d meta=%0h", feed_idx, tok_meta);
        feed_idx++;
        accepted_any = 1'b1;
      end else begin
        stall_cyc++;
        if (accepted_any) ready_gaps++;
      end
    end
  end

  // Output monitor.
  int st_cnt[N] = '{default: 0};
  int run3 = 0;
  int maxrun3 = 0;
  int cal_cnt = 0;
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (cal_fin) cal_cnt++;
    for (int i = 0; i < N; i++) if (stg_start[i]) st_cnt[i]++;
    if (stg_start[N-1]) begin
      run3++;
      if (run3 > maxrun3) maxrun3 = run3;
      check("sb_nonempty", 128'(sb.size() != 0), 128'(1));
      if (sb.size() != 0) begin
        e = sb.pop_front();
        $display("stage3 start meta=%0h last=%0b", stg_meta[(N-1)*MW +: MW], stg_last[N-1]);
        check("s3_meta", stg_meta[(N-1)*MW +: MW], e.meta);
        check("s3_last", stg_last[N-1], e.last);
      end
    end else begin
      run3 = 0;
    end
  end

  task automatic launch(input int num, input logic [N-1:0] mask, input logic [N-1:0] tsk, input int base);
    cfg_num_tiles = CW'(num);
    cfg_skip_mask = mask;
    feed_skip     = tsk;
    feed_num      = num;
    feed_idx      = 0;
    layer_base    = base;
    accepted_any  = 1'b0;
    stall_cyc     = 0;
    ready_gaps    = 0;
    cal_cnt       = 0;
    maxrun3       = 0;
    for (int i = 0; i < N; i++) st_cnt[i] = 0;
    @(negedge clk);
    start   = 1'b1;
    feed_en = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic wait_cal(input int limit, input string tag);
    bit got = 1'b0;
    for (int n = 0; n < limit && !got; n++) begin
      @(negedge clk);
      #2;
      if (cal_fin) got = 1'b1;
    end
    check({tag, "_cal_seen"}, 128'(got), 128'(1));
    check({tag, "_busy_at_cal"}, 128'(busy), 128'(1));
    @(negedge clk);
    #2;
    check({tag, "_busy_after"}, 128'(busy), 128'(0));
    check({tag, "_cal_once"}, 128'(cal_cnt), 128'(1));
    check({tag, "_sb_empty"}, 128'(sb.size()), 128'(0));
    feed_en = 1'b0;
    $display("%s done retired=%0d", tag, tiles_retired);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_ready", 128'(tok_ready), 128'(0));
    check("rst_start", 128'(stg_start), 128'(0));
    check("rst_meta", 128'(stg_meta[MW-1:0]), 128'(0));
    check("rst_retired", 128'(tiles_retired), 128'(0));
    check("rst_err", 128'(err_fin_unexp), 128'(0));
    @(negedge clk);
    reset = 1'b0;
    enb   = 1'b1;

    // 1: plain 4-stage flow, 3 tiles, fin 2 cycles after start
    launch(3, 4'b0000, 4'b0000, 0);
    wait_cal(200, "t1");
    for (int i = 0; i < N; i++) check($sformatf("t1_starts%0d", i), 128'(st_cnt[i]), 128'(3));
    check("t1_retired", 128'(tiles_retired), 128'(3));

    // 2: layer skip of stage 2 plus per-token skip of stage 1
    launch(2, 4'b0100, 4'b0010, 16);
    wait_cal(200, "t2");
    check("t2_starts0", 128'(st_cnt[0]), 128'(2));
    check("t2_starts1", 128'(st_cnt[1]), 128'(0));
    check("t2_starts2", 128'(st_cnt[2]), 128'(0));
    check("t2_starts3", 128'(st_cnt[3]), 128'(2));
    check("t2_retired", 128'(tiles_retired), 128'(2));

    // 3: zero-latency stages, streaming
    for (int i = 0; i < N; i++) lat[i] = 0;
    zl_mask = '1;
    launch(8, 4'b0000, 4'b0000, 32);
    wait_cal(200, "t3");
    check("t3_ready_gaps", 128'(ready_gaps), 128'(0));
    check("t3_run3", 128'(maxrun3), 128'(8));
    check("t3_retired", 128'(tiles_retired), 128'(8));
    zl_mask = '0;

    // 4: slow tail stage back-pressures the pipeline
    lat = '{2, 2, 2, 10};
    launch(6, 4'b0000, 4'b0000, 48);
    wait_cal(400, "t4");
    check("t4_stalled", 128'(stall_cyc != 0), 128'(1));
    for (int i = 0; i < N; i++) check($sformatf("t4_starts%0d", i), 128'(st_cnt[i]), 128'(6));
    check("t4_retired", 128'(tiles_retired), 128'(6));

    // 5: enb freeze, unexpected fin, clear
    check("t5_err_clean", 128'(err_fin_unexp), 128'(0));
    @(negedge clk);
    enb     = 1'b0;
    fin_inj = 4'b0100;
    start   = 1'b1;
    @(negedge clk);
    fin_inj = '0;
    start   = 1'b0;
    enb     = 1'b1;
    #2;
    check("t5_enb_no_err", 128'(err_fin_unexp), 128'(0));
    check("t5_enb_no_start", 128'(busy), 128'(0));
    @(negedge clk);
    fin_inj = 4'b0010;
    @(negedge clk);
    fin_inj = '0;
    #2;
    check("t5_err_set", 128'(err_fin_unexp), 128'(1));
    check("t5_err_nostart", 128'(stg_start), 128'(0));
    repeat (3) @(negedge clk);
    #2;
    check("t5_err_sticky", 128'(err_fin_unexp), 128'(1));
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    #2;
    check("t5_err_clr", 128'(err_fin_unexp), 128'(0));
    check("t5_busy_clr", 128'(busy), 128'(0));
    check("t5_retired_clr", 128'(tiles_retired), 128'(0));

    // 6: empty layer completes without any stage start
    for (int i = 0; i < N; i++) st_cnt[i] = 0;
    cfg_num_tiles = '0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #2;
    check("t6_busy", 128'(busy), 128'(1));
    check("t6_cal_early", 128'(cal_fin), 128'(0));
    @(negedge clk);
    #2;
    check("t6_cal", 128'(cal_fin), 128'(1));
    @(negedge clk);
    #2;
    check("t6_busy_after", 128'(busy), 128'(0));
    check("t6_no_start", 128'(st_cnt[0] + st_cnt[1] + st_cnt[2] + st_cnt[3]), 128'(0));

    // 7: asynchronous reset mid-layer
    lat = '{2, 2, 2, 2};
    launch(4, 4'b0000, 4'b0000, 64);
    repeat (5) @(negedge clk);
    check("t7_busy_pre", 128'(busy), 128'(1));
    @(posedge clk);
    #2;
    reset   = 1'b1;
    feed_en = 1'b0;
    #1;
    check("t7_busy", 128'(busy), 128'(0));
    check("t7_ready", 128'(tok_ready), 128'(0));
    check("t7_start", 128'(stg_start), 128'(0));
    check("t7_meta", 128'(stg_meta[2*MW-1:0]), 128'(0));
    check("t7_last", 128'(stg_last), 128'(0));
    check("t7_retired", 128'(tiles_retired), 128'(0));
    check("t7_cal", 128'(cal_fin), 128'(0));
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/accel_flow_seq.md
Name: accel_flow_seq

Overview:
- Parametrised successor to the fixed four-stage RDATA/COMPS/POOL/WBACK flow controller.
- Generic N_STAGE in-order token pipeline sequencer. Each tile token (metadata such as o_addr, ps_addr, quant_sel and is_out_fin packed into META_W bits) is accepted from an upstream address generator.
- The token is walked through N_STAGE stage controllers with start/fin handshakes.
- Adds per-layer and per-token stage skipping (generalised POOL_ignore), a layer tile counter, flush and unexpected-fin error detection.

Parameters:
- N_STAGE, 4, number of pipeline stages (2..8).
- META_W, 72, width of per-tile metadata token.
- CNT_W, 16, width of tile counters.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- enb  in  1  global enable; low freezes all state
- clear  in  1  synchronous flush
- start  in  1  layer launch pulse
- cfg_num_tiles  in  CNT_W  tiles in layer
- cfg_skip_mask  in  N_STAGE  layer-static stage skip; bit0 ignored
- tok_valid  in  1  upstream token valid
- tok_ready  out  1  token accepted when valid&ready
- tok_meta  in  META_W  token metadata
- tok_skip  in  N_STAGE  per-token stage skip; bit0 ignored
- stg_start  out  N_STAGE  one-cycle start pulse per stage
- stg_meta  out  N_STAGE*META_W  metadata of token held in each slot
- stg_last  out  N_STAGE  slot holds final tile of layer
- stg_fin  in  N_STAGE  stage finished current token
- tiles_retired  out  CNT_W  tokens vacated from last slot
- busy  out  1  layer active
- cal_fin  out  1  one-cycle layer-complete pulse
- err_fin_unexp  out  1  sticky: fin seen while slot not RUN

Behaviour:
- Reset (async, reset=1): all slots IDLE, metadata regs 0, counters 0, top state IDLE, every output 0.
- Top FSM:
  - IDLE -> ACTIVE on start&enb; loads issue_cnt=0 and tiles_retired=0.
  - ACTIVE -> DONE when tiles_retired==cfg_num_tiles.
  - DONE: cal_fin=1 for one cycle -> IDLE.
  - busy=1 in ACTIVE and DONE. Start is ignored outside IDLE.
  - cfg_num_tiles==0: start -> DONE next cycle -> cal_fin.
- Slot i FSM: IDLE, RUN, HOLD, PASS.
  - A token entering slot i goes to PASS if the effective skip bit (cfg_skip_mask[i]|tok_skip[i], i>0) is set; otherwise it goes to RUN.
  - stg_start[i]=1 in the first RUN cycle only.
  - RUN + stg_fin[i]: done. If it cannot advance -> HOLD.
  - PASS is done in its first cycle, with no start pulse.
  - done[i] = PASS | HOLD | (RUN & stg_fin[i]). fin is accepted in the start cycle, so zero-latency stages are allowed.
- Advance rule, combinational ripple from the tail:
  - vac[N-1] = done[N-1].
  - vac[i] = done[i] & (slot[i+1]==IDLE | vac[i+1]).
  - On vac[i], the token moves to slot i+1 at the clock edge. Back-to-back transfers are allowed, so a full pipeline moves one step per cycle with no bubble.
- Intake:
  - tok_ready = ACTIVE & enb & ~clear & issue_cnt<cfg_num_tiles & (slot0 IDLE | vac[0]).
  - Accept at edge t -> slot 0 occupied at t+1 with start (or PASS-equivalent behaviour never applies, since bit0 is not skippable).
  - The stg_last bit is stored with the token when issue_cnt==cfg_num_tiles-1. issue_cnt increments on accept.
- Retire: vac[N-1] increments tiles_retired (saturating at cfg_num_tiles; exceeding it is impossible by construction).
- stg_meta[i] is held stable while the slot is non-IDLE and is undefined-but-stable (last value) while IDLE.
- Unexpected fin: stg_fin[i] while slot i is not RUN sets err_fin_unexp and is otherwise ignored. err_fin_unexp clears only on clear or reset.
- enb=0: no state changes, stg_start forced 0, stg_fin ignored with no error; cal_fin pending is held until enb returns.
- clear (synchronous):
  - Overrides enb and start in the same cycle.
  - All slots go IDLE, counters 0, top IDLE, err cleared.
  - Any in-flight stage must be externally reset.
- Ordering is strictly FIFO; tokens never overtake.
- Widths: counters compare at CNT_W unsigned.

Decomposition:
- Package accel_flow_pkg:
  - Slot state encoding: SLOT_IDLE=0, SLOT_RUN=1, SLOT_HOLD=2, SLOT_PASS=3.
  - Top state encoding: TOP_IDLE, TOP_ACTIVE, TOP_DONE.
  - Default META_W and CNT_W constants.
- Sub-module accel_flow_slot: one slot holding state, meta register, last bit, start generation and done/err logic. It is instantiated N_STAGE times in a generate loop.
- The vac ripple and top FSM stay in accel_flow_seq.

Test Plan:
- N_STAGE=4, num_tiles=3, no skips, every stage fins 2 cycles after start -> each stage sees 3 starts in order; stg_last set on token #3 only; tiles_retired=3; cal_fin exactly once; busy falls the cycle after cal_fin.
- cfg_skip_mask=4'b0100 (pool skipped), num_tiles=2 -> stg_start[2] never pulses; stage 3 metadata equals the issued tokens in order; cal_fin asserted.
- Zero-latency stages (fin tied to start), tok_valid held high, num_tiles=8 -> tok_ready high every cycle after the first accept; stg_start[3] pulses on 8 consecutive cycles.
- Stage 3 fin delayed 10 cycles -> slots 0..2 end in HOLD/RUN, tok_ready drops, no token lost or duplicated; release drains in order.
- stg_fin[1] pulsed while slot 1 IDLE -> err_fin_unexp=1 sticky, no state change; clear -> err 0, all slots IDLE, busy 0.
- num_tiles=0 with start -> cal_fin 2 cycles later, no stg_start; reset asserted mid-layer -> all outputs 0 asynchronously.
